// File: rtl/rle_block_sequencer_pkg.sv
// rtl/rle_block_sequencer_pkg.sv - shared widths, constants and state encoding for the RLE block sequencer
package rle_block_sequencer_pkg;

  localparam int COEF_W    = 10;
  localparam int ROW_N     = 8;
  localparam int ROWS      = 8;
  localparam int ROW_W     = COEF_W * ROW_N;
  localparam int SEL_W     = $clog2(ROW_N);
  localparam int RIDX_W    = $clog2(ROWS);
  localparam int RUN_W     = 6;
  localparam int SYM_RUN_W = 4;
  localparam int ZRL_LEN   = 16;
  localparam logic [SYM_RUN_W-1:0] ZRL_RUN = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EOB,
    S_DONE
  } state_t;

endpackage

// File: rtl/rle_block_sequencer_if.sv
// rtl/rle_block_sequencer_if.sv - row input and symbol output handshakes of the RLE block sequencer
interface rle_block_sequencer_if;
  import rle_block_sequencer_pkg::*;

  logic [ROW_W-1:0]     row_in;
  logic                 row_valid;
  logic                 row_ready;
  logic                 sym_valid;
  logic                 sym_ready;
  logic [SYM_RUN_W-1:0] sym_run;
  logic [COEF_W-1:0]    sym_val;
  logic                 sym_dc;
  logic                 sym_eob;

  modport master (
    output row_in, row_valid, sym_ready,
    input  row_ready, sym_valid, sym_run, sym_val, sym_dc, sym_eob
  );

  modport slave (
    input  row_in, row_valid, sym_ready,
    output row_ready, sym_valid, sym_run, sym_val, sym_dc, sym_eob
  );

endinterface

// File: rtl/rle_block_sequencer_coef_sel.sv
// rtl/rle_block_sequencer_coef_sel.sv - picks coefficient sel out of a held row and flags it zero
module rle_coef_sel
  import rle_block_sequencer_pkg::*;
(
  input  logic [ROW_W-1:0]  row_q,
  input  logic [SEL_W-1:0]  sel,
  output logic [COEF_W-1:0] coef,
  output logic              is_zero
);

  // Coefficient 0 lives in the most significant slice of the row.
  always_comb begin
    coef = '0;
    for (int k = 0; k < ROW_N; k++) begin
      if (sel == SEL_W'(k)) coef = row_q[COEF_W*(ROW_N-k)-1 -: COEF_W];
    end
  end

  assign is_zero = (coef == '0);

endmodule

// File: rtl/rle_block_sequencer.sv
// rtl/rle_block_sequencer.sv - run-length scan controller emitting DC/AC/ZRL/EOB symbols per 8x8 block
module rle_block_sequencer
  import rle_block_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rle_block_sequencer_if.slave bus,
  output logic [SEL_W-1:0]  sel_cnt,
  output logic              blk_done
);

  state_t              state, state_nx;
  logic [ROW_W-1:0]    row_q, row_q_nx;
  logic [RIDX_W-1:0]   row_idx, row_idx_nx;
  logic [SEL_W-1:0]    sel_nx;
  logic [RUN_W-1:0]    run, run_nx, run_after;
  logic [COEF_W-1:0]   coef;
  logic                coef_zero;
  logic                adv;
  logic                row_ready;
  logic                sym_valid;
  logic [SYM_RUN_W-1:0] sym_run;
  logic [COEF_W-1:0]   sym_val;
  logic                sym_dc;
  logic                sym_eob;

  rle_coef_sel u_coef_sel (
    .row_q   (row_q),
    .sel     (sel_cnt),
    .coef    (coef),
    .is_zero (coef_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      row_q   <= '0;
      row_idx <= '0;
      sel_cnt <= '0;
      run     <= '0;
    end else begin
      state   <= state_nx;
      row_q   <= row_q_nx;
      row_idx <= row_idx_nx;
      sel_cnt <= sel_nx;
      run     <= run_nx;
    end
  end

  // Symbol outputs depend only on registered state, so they hold while the consumer stalls.
  always_comb begin
    state_nx   = state;
    row_q_nx   = row_q;
    row_idx_nx = row_idx;
    sel_nx     = sel_cnt;
    run_nx     = run;
    run_after  = run;
    adv        = 1'b0;
    row_ready  = 1'b0;
    sym_valid  = 1'b0;
    sym_run    = '0;
    sym_val    = '0;
    sym_dc     = 1'b0;
    sym_eob    = 1'b0;
    blk_done   = 1'b0;

    case (state)
      S_IDLE: begin
        row_ready = 1'b1;
        if (bus.row_valid) begin
          row_q_nx = bus.row_in;
          sel_nx   = '0;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (row_idx == '0 && sel_cnt == '0) begin
          sym_valid = 1'b1;
          sym_val   = coef;
          sym_dc    = 1'b1;
          adv       = bus.sym_ready;
        end else if (coef_zero) begin
          run_after = run + RUN_W'(1);
          adv       = 1'b1;
        end else if (run >= RUN_W'(ZRL_LEN)) begin
          // Emit one ZRL and revisit the same coefficient next cycle.
          sym_valid = 1'b1;
          sym_run   = ZRL_RUN;
          if (bus.sym_ready) run_after = run - RUN_W'(ZRL_LEN);
        end else begin
          sym_valid = 1'b1;
          sym_run   = run[SYM_RUN_W-1:0];
          sym_val   = coef;
          if (bus.sym_ready) begin
            run_after = '0;
            adv       = 1'b1;
          end
        end
        run_nx = run_after;
        if (adv) begin
          if (sel_cnt != SEL_W'(ROW_N-1)) begin
            sel_nx = sel_cnt + SEL_W'(1);
          end else if (row_idx != RIDX_W'(ROWS-1)) begin
            row_idx_nx = row_idx + RIDX_W'(1);
            state_nx   = S_IDLE;
          end else begin
            state_nx = (run_after != '0) ? S_EOB : S_DONE;
          end
        end
      end
      S_EOB: begin
        sym_valid = 1'b1;
        sym_eob   = 1'b1;
        if (bus.sym_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        blk_done   = 1'b1;
        row_idx_nx = '0;
        run_nx     = '0;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.row_ready = row_ready;
  assign bus.sym_valid = sym_valid;
  assign bus.sym_run   = sym_run;
  assign bus.sym_val   = sym_val;
  assign bus.sym_dc    = sym_dc;
  assign bus.sym_eob   = sym_eob;

endmodule

// File: tb/tb_rle_block_sequencer.sv
// tb/tb_rle_block_sequencer.sv - self-checking bench for rle_block_sequencer against a JPEG RLE reference model
module tb_rle_block_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] sel_cnt;
  logic       blk_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0]  blk [64];
  logic [15:0] exp_q [$];

  rle_block_sequencer_if bus ();

  rle_block_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .sel_cnt  (sel_cnt),
    .blk_done (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Symbol word: {dc, eob, run[3:0], val[9:0]}
  task automatic build_model();
    int run;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 4'd0, blk[0]});
    run = 0;
    for (int k = 1; k < 64; k++) begin
      if (blk[k] == 10'd0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back({2'b00, 4'd15, 10'd0});
          run -= 16;
        end
        exp_q.push_back({2'b00, 4'(run), blk[k]});
        run = 0;
      end
    end
    if (run > 0) exp_q.push_back({2'b01, 4'd0, 10'd0});
  endtask

  function automatic logic [79:0] pack_row(input int r);
    logic [79:0] row;
    row = '0;
    for (int k = 0; k < 8; k++) row[10*(8-k)-1 -: 10] = blk[r*8+k];
    return row;
  endfunction

  task automatic run_block(input string name, input int stall_max, input bit stall_fixed);
    int rows_sent = 0;
    int done_cnt  = 0;
    int got       = 0;
    int expected_n;
    int stall     = 0;
    int stall_len;
    int tail      = 0;
    bit was_stalled = 0;
    logic [15:0] cur, held, exp_sym;
    build_model();
    expected_n = exp_q.size();
    stall_len  = stall_fixed ? stall_max : $urandom_range(stall_max, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rows_sent < 8) begin
        bus.row_valid = 1'b1;
        bus.row_in    = pack_row(rows_sent);
        if (bus.row_ready) rows_sent++;
      end else begin
        bus.row_valid = 1'b0;
      end
      if (blk_done) done_cnt++;
      cur = {bus.sym_dc, bus.sym_eob, bus.sym_run, bus.sym_val};
      if (bus.sym_valid) begin
        if (was_stalled) begin
          vectors++;
          if (cur !== held) begin
            miscompares++;
            $display("FAIL %s stall_hold: got %h required %h", name, cur, held);
          end
        end
        if (stall >= stall_len) begin
          bus.sym_ready = 1'b1;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra_symbol: got %h required none", name, cur);
          end else begin
            exp_sym = exp_q.pop_front();
            if (cur !== exp_sym) begin
              miscompares++;
              $display("FAIL %s symbol[%0d]: got %h required %h", name, got, cur, exp_sym);
            end
          end
          got++;
          stall       = 0;
          stall_len   = stall_fixed ? stall_max : $urandom_range(stall_max, 0);
          was_stalled = 0;
        end else begin
          bus.sym_ready = 1'b0;
          stall++;
          held        = cur;
          was_stalled = 1;
        end
      end else begin
        bus.sym_ready = 1'b0;
      end
      if (done_cnt > 0) tail++;
      if (tail > 3) break;
    end
    bus.row_valid = 1'b0;
    bus.sym_ready = 1'b0;
    vectors++;
    if (got !== expected_n) begin
      miscompares++;
      $display("FAIL %s symbol_count: got %0d required %0d", name, got, expected_n);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s blk_done_pulses: got %0d required 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    @(negedge clk);
    obs = {bus.row_ready, bus.sym_valid, bus.sym_dc, bus.sym_eob, bus.sym_run, bus.sym_val, blk_done, sel_cnt};
    vectors++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h required %h", obs, {1'b1, 21'd0});
    end
  endtask

  task automatic test_dc_only();
    foreach (blk[k]) blk[k] = 10'd0;
    blk[0] = 10'd5;
    run_block("dc_only", 0, 1);
  endtask

  task automatic test_all_neg();
    foreach (blk[k]) blk[k] = 10'h3FF;
    blk[0] = 10'd0;
    run_block("all_neg", 0, 1);
  endtask

  task automatic fill_zrl();
    foreach (blk[k]) blk[k] = 10'd0;
    blk[0]  = 10'd1;
    blk[21] = 10'd3;
  endtask

  task automatic test_zrl();
    fill_zrl();
    run_block("zrl", 0, 1);
  endtask

  task automatic test_last_coef();
    foreach (blk[k]) blk[k] = 10'd0;
    blk[0]  = 10'h2F0;
    blk[63] = 10'd7;
    run_block("last_coef", 0, 1);
    foreach (blk[k]) blk[k] = 10'd0;
    blk[0]  = 10'd9;
    blk[23] = 10'h200;
    run_block("trailing_zeros", 0, 1);
  endtask

  task automatic test_backpressure();
    fill_zrl();
    run_block("backpressure", 5, 1);
  endtask

  task automatic test_random();
    int dens;
    for (int b = 0; b < 8; b++) begin
      dens = $urandom_range(60, 2);
      foreach (blk[k]) blk[k] = ($urandom_range(99, 0) < dens) ? 10'($urandom_range(1023, 1)) : 10'd0;
      blk[0] = 10'($urandom_range(1023, 0));
      run_block($sformatf("random%0d", b), (b % 2 == 0) ? 0 : 3, 0);
    end
  endtask

  task automatic test_reset_mid();
    int rows_sent = 0;
    int extra     = 0;
    logic [21:0] obs;
    foreach (blk[k]) blk[k] = 10'($urandom_range(1023, 0));
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      bus.sym_ready = 1'b1;
      if (rows_sent < 8) begin
        bus.row_valid = 1'b1;
        bus.row_in    = pack_row(rows_sent);
        if (bus.row_ready) rows_sent++;
      end
      if (rows_sent == 4) extra++;
      if (extra == 4) break;
    end
    bus.row_valid = 1'b0;
    bus.sym_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    obs = {bus.row_ready, bus.sym_valid, bus.sym_dc, bus.sym_eob, bus.sym_run, bus.sym_val, blk_done, sel_cnt};
    vectors++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_state: got %h required %h", obs, {1'b1, 21'd0});
    end
    reset = 1'b1;
    foreach (blk[k]) blk[k] = ($urandom_range(3, 0) == 0) ? 10'($urandom_range(1023, 1)) : 10'd0;
    run_block("after_reset", 2, 0);
  endtask

  task automatic test_back_to_back();
    foreach (blk[k]) blk[k] = 10'(k + 1);
    run_block("b2b_a", 0, 1);
    foreach (blk[k]) blk[k] = (k % 17 == 0) ? 10'h3F0 : 10'd0;
    run_block("b2b_b", 0, 1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.row_in    = '0;
    bus.row_valid = 1'b0;
    bus.sym_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_dc_only();
    test_all_neg();
    test_zrl();
    test_last_coef();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
